// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing controller (load-use stall, branch flush, memory-wait freeze)
//
// Purpose:
//   Sits beside decode of the 5-stage MIPS core. It watches ID, ID/EX and EX/MEM, and drives:
//   - the stage enables;
//   - the ID/EX bubble;
//   - the taken-branch flushes;
//   - the PC source select.
//   It also keeps saturating counts of inserted bubbles and of flushed branches.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_opcode, id_rs, id_rt       fields of the instruction sitting in ID
//   ex_mem_read, ex_rt            LW indicator and destination register of the instruction in EX
//   mem_branch, mem_zero          BEQ in MEM and its ALU zero flag
//   mem_busy                      data memory not ready this cycle
//   pc_write, pc_src              PC load enable, 1 = branch target
//   if_id_write .. mem_wb_write   pipeline latch enables
//   id_ex_bubble                  zero the ID/EX control fields
//   flush_if_id/id_ex/ex_mem      clear the respective latch on this edge
//   state                         FSM state (debug): 0 RUN, 1 LU_STALL, 2 MEM_WAIT
//   stall_cnt, flush_cnt          saturating statistics
module hazard_ctrl #(
   parameter int LU_STALL_CYCLES = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             mem_branch,
   input  logic             mem_zero,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             pc_src,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [2:0]       LU_RELOAD = 3'(LU_STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   state_t           saved_q, saved_d;
   state_t           eff_state;
   logic [2:0]       lu_q, lu_d;
   logic [2:0]       saved_lu_q, saved_lu_d;
   logic [2:0]       eff_lu;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             stall_inc, flush_inc;

   logic uses_rs, uses_rt, lu_hit, taken;

   // Register usage of the instruction in ID; NOP and unknown opcodes read nothing.
   always_comb begin
      uses_rs = (id_opcode == OP_RTYPE) || (id_opcode == OP_LW) ||
                (id_opcode == OP_SW)    || (id_opcode == OP_BEQ);
      uses_rt = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) ||
                (id_opcode == OP_BEQ);
   end

   assign lu_hit = ex_mem_read && (ex_rt != 5'd0) &&
                   ((uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt)));
   assign taken  = mem_branch && mem_zero;

   // While frozen in MEM_WAIT, the pre-freeze state is what the rules act on once the
   // memory releases. This lets a single cycle both leave the wait and resume the stall
   // or branch handling.
   always_comb begin
      if (state_q == MEM_WAIT) begin
         eff_state = saved_q;
         eff_lu    = saved_lu_q;
      end else begin
         eff_state = state_q;
         eff_lu    = lu_q;
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      pc_src       = 1'b0;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b0;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      state_d      = eff_state;
      lu_d         = eff_lu;
      saved_d      = saved_q;
      saved_lu_d   = saved_lu_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;

      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         state_d      = RUN;
         lu_d         = 3'd0;
      end else if (mem_busy) begin
         // Freeze everything; a taken branch stays parked in EX/MEM until release.
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
         state_d      = MEM_WAIT;
         lu_d         = lu_q;
         saved_d      = eff_state;
         saved_lu_d   = eff_lu;
      end else if (taken) begin
         pc_src       = 1'b1;
         flush_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
         flush_ex_mem = 1'b1;
         state_d      = RUN;
         lu_d         = 3'd0;
         flush_inc    = 1'b1;
      end else if (eff_state == LU_STALL) begin
         // The bubble now occupies EX, so lu_hit is meaningless here; just count down.
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         stall_inc    = 1'b1;
         lu_d         = eff_lu - 3'd1;
         state_d      = (eff_lu == 3'd1) ? RUN : LU_STALL;
      end else if (lu_hit) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         stall_inc    = 1'b1;
         if (LU_STALL_CYCLES > 1) begin
            lu_d    = LU_RELOAD;
            state_d = LU_STALL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         saved_q    <= RUN;
         lu_q       <= 3'd0;
         saved_lu_q <= 3'd0;
         stall_q    <= '0;
         flush_q    <= '0;
      end else begin
         state_q    <= state_d;
         saved_q    <= saved_d;
         lu_q       <= lu_d;
         saved_lu_q <= saved_lu_d;
         if (stall_inc && (stall_q != CNT_MAX)) stall_q <= stall_q + 1'b1;
         if (flush_inc && (flush_q != CNT_MAX)) flush_q <= flush_q + 1'b1;
      end
   end

   assign state     = state_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (instances with 1 and 3 stall cycles)
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] id_opcode;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       ex_mem_read, mem_branch, mem_zero, mem_busy;

   logic        a_pcw, a_src, a_ifid, a_idex, a_bub, a_exmem, a_memwb, a_fi, a_fd, a_fe;
   logic [1:0]  a_st;
   logic [15:0] a_sc, a_fc;
   logic        b_pcw, b_src, b_ifid, b_idex, b_bub, b_exmem, b_memwb, b_fi, b_fd, b_fe;
   logic [1:0]  b_st;
   logic [3:0]  b_sc, b_fc;

   always #5 clk = ~clk;

   hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
      .mem_busy(mem_busy), .pc_write(a_pcw), .pc_src(a_src), .if_id_write(a_ifid),
      .id_ex_write(a_idex), .id_ex_bubble(a_bub), .ex_mem_write(a_exmem), .mem_wb_write(a_memwb),
      .flush_if_id(a_fi), .flush_id_ex(a_fd), .flush_ex_mem(a_fe), .state(a_st),
      .stall_cnt(a_sc), .flush_cnt(a_fc));

   hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
      .mem_busy(mem_busy), .pc_write(b_pcw), .pc_src(b_src), .if_id_write(b_ifid),
      .id_ex_write(b_idex), .id_ex_bubble(b_bub), .ex_mem_write(b_exmem), .mem_wb_write(b_memwb),
      .flush_if_id(b_fi), .flush_id_ex(b_fd), .flush_ex_mem(b_fe), .state(b_st),
      .stall_cnt(b_sc), .flush_cnt(b_fc));

   // Output vector order: pc_write, pc_src, if_id, id_ex, bubble, ex_mem, mem_wb, fl_if, fl_id, fl_ex
   localparam logic [9:0] O_RST   = 10'b0000100000;
   localparam logic [9:0] M_RST   = 10'b1110100111;
   localparam logic [9:0] O_BUSY  = 10'b0000000000;
   localparam logic [9:0] O_TAKEN = 10'b1111011111;
   localparam logic [9:0] O_STALL = 10'b0001111000;
   localparam logic [9:0] O_RUN   = 10'b1011011000;

   localparam logic [5:0] RT = 6'd0, LW = 6'd35, SW = 6'd43, BEQ = 6'd4, NOP = 6'd32, JMP = 6'd2;

   typedef struct packed {
      logic [9:0]  o;
      logic [1:0]  s;
      logic [15:0] sc;
      logic [15:0] fc;
   } inst_exp_t;

   typedef struct packed {
      inst_exp_t [1:0] i;
      logic [9:0]      m;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int errors = 0;
   int pushed = 0;
   int popped = 0;

   // Reference model: remaining bubble cycles, whether the memory froze us last cycle, counts.
   int nn[2]   = '{1, 3};
   int mx[2]   = '{65535, 15};
   int pend[2] = '{0, 0};
   int wt[2]   = '{0, 0};
   int sc[2]   = '{0, 0};
   int fc[2]   = '{0, 0};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] ert, input logic br, input logic z,
                       input logic b);
      exp_t e;
      logic ur, ut, hit, tk;
      @(posedge clk);
      #1;
      rst = r; id_opcode = op; id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = ert;
      mem_branch = br; mem_zero = z; mem_busy = b;
      ur  = (op == RT) || (op == LW) || (op == SW) || (op == BEQ);
      ut  = (op == RT) || (op == SW) || (op == BEQ);
      hit = mr && (ert != 0) && ((ur && ert == rs) || (ut && ert == rt));
      tk  = br && z;
      e.m = r ? M_RST : 10'h3ff;
      for (int i = 0; i < 2; i++) begin
         e.i[i].s  = (wt[i] != 0) ? 2'd2 : (pend[i] > 0 ? 2'd1 : 2'd0);
         e.i[i].sc = 16'(sc[i]);
         e.i[i].fc = 16'(fc[i]);
         if (r)                          e.i[i].o = O_RST;
         else if (b)                     e.i[i].o = O_BUSY;
         else if (tk)                    e.i[i].o = O_TAKEN;
         else if (pend[i] > 0 || hit)    e.i[i].o = O_STALL;
         else                            e.i[i].o = O_RUN;
         if (r) begin
            pend[i] = 0; wt[i] = 0; sc[i] = 0; fc[i] = 0;
         end else if (b) begin
            wt[i] = 1;
         end else begin
            wt[i] = 0;
            if (tk) begin
               pend[i] = 0;
               if (fc[i] < mx[i]) fc[i]++;
            end else if (pend[i] > 0) begin
               pend[i]--;
               if (sc[i] < mx[i]) sc[i]++;
            end else if (hit) begin
               pend[i] = nn[i] - 1;
               if (sc[i] < mx[i]) sc[i]++;
            end
         end
      end
      q.push_back(e);
      pushed++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, NOP, 0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         popped++;
         chk("n1_outputs", int'({a_pcw, a_src, a_ifid, a_idex, a_bub, a_exmem, a_memwb, a_fi, a_fd, a_fe} & e.m),
             int'(e.i[0].o & e.m));
         chk("n1_state", int'(a_st), int'(e.i[0].s));
         chk("n1_stall_cnt", int'(a_sc), int'(e.i[0].sc));
         chk("n1_flush_cnt", int'(a_fc), int'(e.i[0].fc));
         chk("n3_outputs", int'({b_pcw, b_src, b_ifid, b_idex, b_bub, b_exmem, b_memwb, b_fi, b_fd, b_fe} & e.m),
             int'(e.i[1].o & e.m));
         chk("n3_state", int'(b_st), int'(e.i[1].s));
         chk("n3_stall_cnt", int'(b_sc), int'(e.i[1].sc));
         chk("n3_flush_cnt", int'(b_fc), int'(e.i[1].fc));
      end
   end

   initial begin
      rst = 1'b1; id_opcode = NOP; id_rs = 0; id_rt = 0; ex_mem_read = 0; ex_rt = 0;
      mem_branch = 0; mem_zero = 0; mem_busy = 0;
      step(1, NOP, 0, 0, 0, 0, 0, 0, 0);
      step(1, NOP, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // T1: LW r1 then ADD r3,r1,r2
      step(0, LW, 0, 1, 0, 0, 0, 0, 0);
      step(0, RT, 1, 2, 1, 1, 0, 0, 0);
      step(0, RT, 1, 2, 0, 0, 0, 0, 0);
      idle(3);
      // T2: LW r0 then ADD using r0; LW r1 then NOP
      step(0, RT, 0, 2, 1, 0, 0, 0, 0);
      step(0, NOP, 1, 1, 1, 1, 0, 0, 0);
      step(0, JMP, 1, 1, 1, 1, 0, 0, 0);
      idle(1);
      // T3: LW r2 then SW r2 (rt match)
      step(0, SW, 0, 2, 1, 2, 0, 0, 0);
      idle(4);
      // T4: taken BEQ together with a load-use pair, then abort a running stall
      step(0, RT, 3, 4, 1, 3, 1, 1, 0);
      step(0, BEQ, 5, 1, 1, 5, 0, 0, 0);
      step(0, RT, 5, 1, 0, 0, 1, 1, 0);
      step(0, RT, 0, 0, 0, 0, 1, 0, 0);
      idle(3);
      // T5: memory busy 4 cycles with a taken BEQ in MEM
      for (int k = 0; k < 4; k++) step(0, NOP, 0, 0, 0, 0, 1, 1, 1);
      step(0, NOP, 0, 0, 0, 0, 1, 1, 0);
      idle(2);
      // memory busy in the middle of a stall; stall resumes on release
      step(0, RT, 6, 7, 1, 7, 0, 0, 0);
      step(0, NOP, 0, 0, 0, 0, 0, 0, 1);
      step(0, NOP, 0, 0, 0, 0, 0, 0, 1);
      idle(4);
      // T6: reset during LU_STALL
      step(0, LW, 8, 0, 1, 8, 0, 0, 0);
      step(1, NOP, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      // randomized traffic with concentrated register numbers to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] op;
         case ($urandom_range(0, 5))
            0: op = RT; 1: op = LW; 2: op = SW; 3: op = BEQ; 4: op = NOP; default: op = JMP;
         endcase
         step(($urandom_range(0, 199) == 0), op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0));
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", popped, pushed);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
